// File: rtl/multicycle_control.sv
// Multicycle MIPS-style main controller: one FSM register plus combinational
// decode of the datapath controls from the current state.
module multicycle_control (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] OP,
    input  logic       Zero,
    input  logic       MemReady,
    output logic       IorD,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       RegDst,
    output logic       MemtoReg,
    output logic       RegWrite,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [2:0] ALUOp,
    output logic [1:0] PCSource,
    output logic       PCWrite,
    output logic       Illegal,
    output logic [3:0] State
);

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXEC_R = 4'd6,
        S_WB_R   = 4'd7,
        S_EXEC_I = 4'd8,
        S_WB_I   = 4'd9,
        S_BRANCH = 4'd10,
        S_JUMP   = 4'd11
    } state_e;

    localparam logic [5:0] OP_R    = 6'h00;
    localparam logic [5:0] OP_J    = 6'h02;
    localparam logic [5:0] OP_BEQ  = 6'h04;
    localparam logic [5:0] OP_BNE  = 6'h05;
    localparam logic [5:0] OP_ADDI = 6'h08;
    localparam logic [5:0] OP_ANDI = 6'h0C;
    localparam logic [5:0] OP_ORI  = 6'h0D;
    localparam logic [5:0] OP_LUI  = 6'h0F;
    localparam logic [5:0] OP_LW   = 6'h23;
    localparam logic [5:0] OP_SW   = 6'h2B;

    state_e     state_q, state_d;
    logic       illegal_q, illegal_d;
    logic [2:0] imm_aluop;
    logic       branch_taken;

    always_comb begin
        state_d   = S_FETCH;
        illegal_d = illegal_q;
        case (state_q)
            S_FETCH:  state_d = MemReady ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (OP)
                    OP_LW, OP_SW:                       state_d = S_MEMADR;
                    OP_R:                               state_d = S_EXEC_R;
                    OP_ADDI, OP_ANDI, OP_ORI, OP_LUI:   state_d = S_EXEC_I;
                    OP_BEQ, OP_BNE:                     state_d = S_BRANCH;
                    OP_J:                               state_d = S_JUMP;
                    default: begin
                        state_d   = S_FETCH;
                        illegal_d = 1'b1;
                    end
                endcase
            end
            S_MEMADR: state_d = (OP == OP_SW) ? S_MEMWR : S_MEMRD;
            S_MEMRD:  state_d = MemReady ? S_MEMWB : S_MEMRD;
            S_MEMWR:  state_d = MemReady ? S_FETCH : S_MEMWR;
            S_EXEC_R: state_d = S_WB_R;
            S_EXEC_I: state_d = S_WB_I;
            default:  state_d = S_FETCH;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= S_FETCH;
            illegal_q <= 1'b0;
        end else begin
            // NOTE: non-blocking so every flop samples the pre-edge values.
            state_q   <= state_d;
            illegal_q <= illegal_d;
        end
    end

    // OP is stable for the whole instruction, so WB_I can re-decode it.
    always_comb begin
        case (OP)
            OP_ADDI: imm_aluop = 3'b110;
            OP_ANDI: imm_aluop = 3'b011;
            OP_ORI:  imm_aluop = 3'b101;
            OP_LUI:  imm_aluop = 3'b001;
            default: imm_aluop = 3'b000;
        endcase
    end

    assign branch_taken = ((OP == OP_BEQ) && Zero) || ((OP == OP_BNE) && !Zero);

    always_comb begin
        // NOTE: every output defaults to 0 first so no path leaves a latch.
        IorD     = 1'b0;
        MemRead  = 1'b0;
        MemWrite = 1'b0;
        IRWrite  = 1'b0;
        RegDst   = 1'b0;
        MemtoReg = 1'b0;
        RegWrite = 1'b0;
        ALUSrcA  = 1'b0;
        ALUSrcB  = 2'd0;
        ALUOp    = 3'b000;
        PCSource = 2'd0;
        PCWrite  = 1'b0;
        // Reset is asynchronous, so the controls are also cut off combinationally.
        if (reset) begin
            case (state_q)
                S_FETCH: begin
                    MemRead = 1'b1;
                    ALUSrcB = 2'd1;
                    ALUOp   = 3'b010;
                    IRWrite = MemReady;
                    PCWrite = MemReady;
                end
                S_DECODE: begin
                    ALUSrcB = 2'd3;
                    ALUOp   = 3'b010;
                end
                S_MEMADR: begin
                    ALUSrcA = 1'b1;
                    ALUSrcB = 2'd2;
                    ALUOp   = 3'b010;
                end
                S_MEMRD: begin
                    IorD    = 1'b1;
                    MemRead = 1'b1;
                end
                S_MEMWB: begin
                    MemtoReg = 1'b1;
                    RegWrite = 1'b1;
                end
                S_MEMWR: begin
                    IorD     = 1'b1;
                    MemWrite = 1'b1;
                end
                S_EXEC_R: begin
                    ALUSrcA = 1'b1;
                    ALUOp   = 3'b111;
                end
                S_WB_R: begin
                    RegDst   = 1'b1;
                    RegWrite = 1'b1;
                end
                S_EXEC_I: begin
                    ALUSrcA = 1'b1;
                    ALUSrcB = 2'd2;
                    ALUOp   = imm_aluop;
                end
                S_WB_I: begin
                    RegWrite = 1'b1;
                    ALUOp    = imm_aluop;
                end
                S_BRANCH: begin
                    ALUSrcA  = 1'b1;
                    ALUOp    = 3'b100;
                    PCSource = 2'd1;
                    PCWrite  = branch_taken;
                end
                S_JUMP: begin
                    PCSource = 2'd2;
                    PCWrite  = 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign Illegal = illegal_q;
    assign State   = state_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Randomized bench for multicycle_control: a per-opcode state-path model plus a
// per-state control table, checked cycle by cycle, with the directed scenarios first.
module tb_multicycle_control;

    typedef struct packed {
        logic       iord;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [2:0] alu_op;
        logic [1:0] pc_source;
        logic       pc_write;
    } ctrl_t;

    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] OP;
    logic       Zero;
    logic       MemReady;
    logic       IorD, MemRead, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite, ALUSrcA;
    logic [1:0] ALUSrcB;
    logic [2:0] ALUOp;
    logic [1:0] PCSource;
    logic       PCWrite;
    logic       Illegal;
    logic [3:0] State;

    int checks   = 0;
    int failures = 0;
    bit exp_illegal;
    int path[$];

    multicycle_control dut (
        .clk(clk), .reset(reset), .OP(OP), .Zero(Zero), .MemReady(MemReady),
        .IorD(IorD), .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite),
        .RegDst(RegDst), .MemtoReg(MemtoReg), .RegWrite(RegWrite), .ALUSrcA(ALUSrcA),
        .ALUSrcB(ALUSrcB), .ALUOp(ALUOp), .PCSource(PCSource), .PCWrite(PCWrite),
        .Illegal(Illegal), .State(State)
    );

    always #5 clk = ~clk;

    initial begin
        #2ms;
        $display("FAIL timeout: simulation exceeded its time budget");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic ctrl_t observed();
        return ctrl_t'({IorD, MemRead, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite,
                        ALUSrcA, ALUSrcB, ALUOp, PCSource, PCWrite});
    endfunction

    function automatic logic [2:0] imm_op(input logic [5:0] op);
        case (op)
            6'h08:   return 3'b110;
            6'h0C:   return 3'b011;
            6'h0D:   return 3'b101;
            default: return 3'b001;
        endcase
    endfunction

    // Sequence of states an instruction visits, ignoring memory waits.
    function automatic void build_path(input logic [5:0] op);
        path = {0, 1};
        case (op)
            6'h00:                      path = {path, 6, 7};
            6'h08, 6'h0C, 6'h0D, 6'h0F: path = {path, 8, 9};
            6'h23:                      path = {path, 2, 3, 4};
            6'h2B:                      path = {path, 2, 5};
            6'h04, 6'h05:               path = {path, 10};
            6'h02:                      path = {path, 11};
            default: ;
        endcase
    endfunction

    function automatic ctrl_t exp_ctrl(input int s, input logic [5:0] op, input logic mr,
                                       input logic z);
        ctrl_t c = '0;
        case (s)
            0: begin
                c.mem_read = 1; c.alu_src_b = 1; c.alu_op = 3'b010;
                c.ir_write = mr; c.pc_write = mr;
            end
            1: begin c.alu_src_b = 3; c.alu_op = 3'b010; end
            2: begin c.alu_src_a = 1; c.alu_src_b = 2; c.alu_op = 3'b010; end
            3: begin c.iord = 1; c.mem_read = 1; end
            4: begin c.mem_to_reg = 1; c.reg_write = 1; end
            5: begin c.iord = 1; c.mem_write = 1; end
            6: begin c.alu_src_a = 1; c.alu_op = 3'b111; end
            7: begin c.reg_dst = 1; c.reg_write = 1; end
            8: begin c.alu_src_a = 1; c.alu_src_b = 2; c.alu_op = imm_op(op); end
            9: begin c.reg_write = 1; c.alu_op = imm_op(op); end
            10: begin
                c.alu_src_a = 1; c.alu_op = 3'b100; c.pc_source = 1;
                c.pc_write = (op == 6'h04) ? z : ~z;
            end
            11: begin c.pc_source = 2; c.pc_write = 1; end
            default: ;
        endcase
        return c;
    endfunction

    function automatic bit is_legal(input logic [5:0] op);
        case (op)
            6'h00, 6'h02, 6'h04, 6'h05, 6'h08, 6'h0C, 6'h0D, 6'h0F, 6'h23, 6'h2B: return 1;
            default: return 0;
        endcase
    endfunction

    // Runs one instruction; inputs are driven #1 after posedge, outputs checked at negedge.
    // With abort set, reset is pulsed during the first memory-wait cycle of MEMRD/MEMWR.
    task automatic run_instr(input logic [5:0] op, input int fw, input int mw, input logic z,
                             input bit abort);
        int waits;
        build_path(op);
        OP   = op;
        Zero = z;
        foreach (path[i]) begin
            waits = (path[i] == 0) ? fw : ((path[i] == 3 || path[i] == 5) ? mw : 0);
            for (int c = 0; c <= waits; c++) begin
                if (path[i] == 0 || path[i] == 3 || path[i] == 5)
                    MemReady = (c == waits);
                else
                    MemReady = 1'($urandom);
                @(negedge clk);
                check($sformatf("state op=%0h", op), 32'(State), 32'(path[i]));
                check($sformatf("ctrl op=%0h s=%0d", op, path[i]), 32'(observed()),
                      32'(exp_ctrl(path[i], op, MemReady, z)));
                check("illegal", 32'(Illegal), 32'(exp_illegal));
                if (abort && c == 0 && waits > 0 && (path[i] == 3 || path[i] == 5)) begin
                    #2 reset = 1'b0;
                    #1;
                    check("abort state", 32'(State), 32'd0);
                    check("abort ctrl", 32'(observed()), 32'd0);
                    check("abort illegal", 32'(Illegal), 32'd0);
                    exp_illegal = 0;
                    @(posedge clk);
                    #1;
                    check("abort held ctrl", 32'(observed()), 32'd0);
                    reset = 1'b1;
                    return;
                end
                @(posedge clk);
                #1;
            end
            if (path[i] == 1 && !is_legal(op))
                exp_illegal = 1;
        end
    endtask

    initial begin
        logic [5:0] legal_ops [10];
        logic [5:0] op;
        legal_ops = '{6'h00, 6'h08, 6'h0C, 6'h0D, 6'h0F, 6'h23, 6'h2B, 6'h04, 6'h05, 6'h02};
        reset       = 1'b0;
        OP          = 6'h00;
        Zero        = 1'b0;
        MemReady    = 1'b1;
        exp_illegal = 0;

        // Outputs stay forced to zero while reset is held, whatever the inputs do.
        for (int i = 0; i < 3; i++) begin
            MemReady = 1'($urandom);
            OP       = 6'($urandom);
            @(negedge clk);
            check("reset state", 32'(State), 32'd0);
            check("reset ctrl", 32'(observed()), 32'd0);
            check("reset illegal", 32'(Illegal), 32'd0);
        end
        @(posedge clk);
        #1 reset = 1'b1;

        run_instr(6'h00, 0, 0, 1'b0, 0);    // V1
        run_instr(6'h23, 3, 2, 1'b0, 0);    // V2
        run_instr(6'h04, 0, 0, 1'b1, 0);    // V3 taken
        run_instr(6'h05, 0, 0, 1'b1, 0);    // V3 not taken
        run_instr(6'h3F, 0, 0, 1'b0, 0);    // V4 illegal
        run_instr(6'h02, 1, 0, 1'b0, 0);    // V4 jump, Illegal stays set
        run_instr(6'h2B, 0, 2, 1'b0, 1);    // V5 reset during MEMWR
        run_instr(6'h0F, 0, 0, 1'b0, 0);    // V6

        repeat (200) begin
            if ($urandom_range(7) == 0) op = 6'($urandom);
            else                        op = legal_ops[$urandom_range(9)];
            run_instr(op, $urandom_range(2), $urandom_range(2), 1'($urandom),
                      $urandom_range(15) == 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
